// File: rtl/fle_fabric_param.sv
//------------------------------------------------------------------------------
// fle_fabric_param : K-input fracturable LUT with carry, two FFs and a
// serial configuration chain.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fle_fabric_param #(
  parameter int K = 4
) (
  input  logic         fabric_clk,
  input  logic         fabric_reset,
  input  logic         cfg_en,
  input  logic         ccff_head,
  input  logic         Test_en,
  input  logic         fabric_ce,
  input  logic [K-1:0] fabric_in,
  input  logic         fabric_reg_in,
  input  logic         fabric_sc_in,
  input  logic         fabric_cin,
  output logic [1:0]   fabric_out,
  output logic         fabric_reg_out,
  output logic         fabric_sc_out,
  output logic         fabric_cout,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int LUT_N = 1 << K;
  localparam int HALF  = LUT_N / 2;
  localparam int CFG_W = LUT_N + 6;
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CFG_W);

  localparam logic [1:0] S_UNCFG   = 2'd0;
  localparam logic [1:0] S_LOADING = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;

  logic [CFG_W-1:0] r_cfg;
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_ff0;
  logic             r_ff1;
  logic             w_done;

  // Configuration chain shifts whenever enabled, regardless of state.
  always_ff @(posedge fabric_clk) begin
    if (fabric_reset) begin
      r_cfg <= '0;
    end else if (cfg_en) begin
      r_cfg <= {r_cfg[CFG_W-2:0], ccff_head};
    end
  end

  always_ff @(posedge fabric_clk) begin
    if (fabric_reset) begin
      r_state <= S_UNCFG;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_UNCFG, S_ACTIVE: begin
        if (cfg_en) w_next_state = S_LOADING;
      end
      S_LOADING: begin
        if (!cfg_en) w_next_state = (r_cnt == C_CNT_FULL) ? S_ACTIVE : S_UNCFG;
      end
      default: w_next_state = S_UNCFG;
    endcase
  end

  always_comb begin
    w_done = (r_state == S_ACTIVE);
  end

  // Counter restarts at 1 on the entry shift; error is cleared on entry.
  always_ff @(posedge fabric_clk) begin
    if (fabric_reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state != S_LOADING) begin
      if (cfg_en) begin
        r_cnt <= CNT_W'(1);
        r_err <= 1'b0;
      end
    end else if (cfg_en) begin
      if (r_cnt != C_CNT_FULL) r_cnt <= r_cnt + 1'b1;
    end else if (r_cnt != C_CNT_FULL) begin
      r_err <= 1'b1;
    end
  end

  logic [LUT_N-1:0] w_lut;
  logic [HALF-1:0]  w_lo_tbl;
  logic [HALF-1:0]  w_hi_tbl;
  logic             w_h0, w_h1, w_f;
  logic             w_frac, w_arith, w_osel0, w_osel1, w_dsel0, w_dsel1;
  logic             w_c0, w_c1, w_cout;
  logic             w_d0, w_d1;

  assign w_lut    = r_cfg[LUT_N-1:0];
  assign w_lo_tbl = w_lut[HALF-1:0];
  assign w_hi_tbl = w_lut[LUT_N-1:HALF];
  assign w_h0     = w_lo_tbl[fabric_in[K-2:0]];
  assign w_h1     = w_hi_tbl[fabric_in[K-2:0]];
  assign w_f      = w_lut[fabric_in];

  assign w_frac  = r_cfg[LUT_N];
  assign w_arith = r_cfg[LUT_N+1];
  assign w_osel0 = r_cfg[LUT_N+2];
  assign w_osel1 = r_cfg[LUT_N+3];
  assign w_dsel0 = r_cfg[LUT_N+4];
  assign w_dsel1 = r_cfg[LUT_N+5];

  always_comb begin
    w_cout = 1'b0;
    if (w_arith) begin
      w_c0   = w_h0 ^ fabric_cin;
      w_cout = w_h1 | (w_h0 & fabric_cin);
      w_c1   = w_cout;
    end else if (w_frac) begin
      w_c0 = w_h0;
      w_c1 = w_h1;
    end else begin
      w_c0 = w_f;
      w_c1 = w_f;
    end
  end

  assign w_d0 = w_dsel0 ? fabric_reg_in : w_c0;
  assign w_d1 = w_dsel1 ? r_ff0 : w_c1;

  // Scan mode overrides the clock enable; FFs are held clear unless active.
  always_ff @(posedge fabric_clk) begin
    if (fabric_reset || (r_state != S_ACTIVE)) begin
      r_ff0 <= 1'b0;
      r_ff1 <= 1'b0;
    end else if (Test_en) begin
      r_ff0 <= fabric_sc_in;
      r_ff1 <= r_ff0;
    end else if (fabric_ce) begin
      r_ff0 <= w_d0;
      r_ff1 <= w_d1;
    end
  end

  logic w_active;
  assign w_active = w_done && !fabric_reset;

  assign fabric_out     = w_active ? {(w_osel1 ? r_ff1 : w_c1), (w_osel0 ? r_ff0 : w_c0)} : 2'b00;
  assign fabric_cout    = w_active && w_arith && w_cout;
  assign fabric_reg_out = !fabric_reset && r_ff1;
  assign fabric_sc_out  = !fabric_reset && r_ff1;
  assign ccff_tail      = !fabric_reset && r_cfg[CFG_W-1];
  assign cfg_done       = !fabric_reset && w_done;
  assign cfg_err        = !fabric_reset && r_err;

endmodule

`default_nettype wire

// File: tb/tb_fle_fabric_param.sv
//------------------------------------------------------------------------------
// tb_fle_fabric_param : directed scoreboard bench for fle_fabric_param (K=4).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fle_fabric_param;

  localparam int K     = 4;
  localparam int CFG_W = 22;

  localparam logic [21:0] W_AND   = 22'h008000;
  localparam logic [21:0] W_ARITH = 22'h028866;
  localparam logic [21:0] W_FRAC  = 22'h018866;
  localparam logic [21:0] W_SCAN  = 22'h0C8000;
  localparam logic [21:0] W_DSEL  = 22'h3C8000;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_en, ccff_head, test_en, ce, reg_in, sc_in, cin;
  logic [K-1:0] fin;
  logic [1:0]   fout;
  logic         reg_out, sc_out, cout, tail, done, err;

  always #5 clk = ~clk;

  fle_fabric_param #(.K(K)) dut (
    .fabric_clk     (clk),
    .fabric_reset   (rst),
    .cfg_en         (cfg_en),
    .ccff_head      (ccff_head),
    .Test_en        (test_en),
    .fabric_ce      (ce),
    .fabric_in      (fin),
    .fabric_reg_in  (reg_in),
    .fabric_sc_in   (sc_in),
    .fabric_cin     (cin),
    .fabric_out     (fout),
    .fabric_reg_out (reg_out),
    .fabric_sc_out  (sc_out),
    .fabric_cout    (cout),
    .ccff_tail      (tail),
    .cfg_done       (done),
    .cfg_err        (err)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  // MSB first so bit CFG_W-1 of the word lands at the chain MSB.
  task automatic shift_word(input logic [21:0] w);
    for (int i = CFG_W - 1; i >= 0; i--) begin
      cfg_en    = 1'b1;
      ccff_head = w[i];
      tick();
    end
  endtask

  task automatic shift_ones(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en    = 1'b1;
      ccff_head = 1'b1;
      tick();
    end
  endtask

  task automatic end_load();
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_en = 1'b0; ccff_head = 1'b0; test_en = 1'b0; ce = 1'b0;
    reg_in = 1'b0; sc_in = 1'b0; cin = 1'b0; fin = '0;
    tick(); tick();

    // Reset state
    exp_push("rst_done", 0); chk(32'(done));
    exp_push("rst_err", 0);  chk(32'(err));
    exp_push("rst_out", 0);  chk(32'(fout));
    exp_push("rst_tail", 0); chk(32'(tail));
    exp_push("rst_cout", 0); chk(32'(cout));
    rst = 1'b0;
    tick();

    // AND-4 table: out only for input 0xF
    shift_word(W_AND);
    exp_push("load_done_low", 0); chk(32'(done));
    end_load();
    exp_push("and_done", 1); chk(32'(done));
    exp_push("and_err", 0);  chk(32'(err));
    fin = 4'hF; #1;
    exp_push("and_f", 2'b11); chk(32'(fout));
    fin = 4'hE; #1;
    exp_push("and_e", 2'b00); chk(32'(fout));
    exp_push("and_cout", 0);  chk(32'(cout));

    // Short load aborts with sticky error
    fin = 4'hF;
    shift_ones(10);
    end_load();
    exp_push("short_done", 0); chk(32'(done));
    exp_push("short_err", 1);  chk(32'(err));
    exp_push("short_out", 0);  chk(32'(fout));
    tick();
    exp_push("short_err_sticky", 1); chk(32'(err));
    cfg_en = 1'b1; ccff_head = 1'b0; tick();
    exp_push("reload_err_clr", 0); chk(32'(err));
    shift_word(W_AND);
    end_load();
    exp_push("reload_done", 1); chk(32'(done));
    exp_push("reload_out", 2'b11); chk(32'(fout));

    // Arithmetic mode: H0 = xor, H1 = and
    shift_word(W_ARITH);
    end_load();
    fin = 4'b0011; cin = 1'b1; #1;
    exp_push("arith11_out", 2'b11); chk(32'(fout));
    exp_push("arith11_cout", 1);    chk(32'(cout));
    fin = 4'b0001; #1;
    exp_push("arith01_out", 2'b10); chk(32'(fout));
    exp_push("arith01_cout", 1);    chk(32'(cout));
    fin = 4'b0000; #1;
    exp_push("arith00_out", 2'b01); chk(32'(fout));
    exp_push("arith00_cout", 0);    chk(32'(cout));

    // Fractured mode
    shift_word(W_FRAC);
    end_load();
    fin = 4'b0011; #1;
    exp_push("frac_out", 2'b10); chk(32'(fout));
    exp_push("frac_cout", 0);    chk(32'(cout));
    cin = 1'b0;

    // Scan chain, hold and functional load through the FFs
    shift_word(W_SCAN);
    end_load();
    test_en = 1'b1; sc_in = 1'b1; tick();
    exp_push("scan1_out", 2'b01); chk(32'(fout));
    exp_push("scan1_sc", 0);      chk(32'(sc_out));
    sc_in = 1'b0; tick();
    exp_push("scan2_out", 2'b10); chk(32'(fout));
    exp_push("scan2_sc", 1);      chk(32'(sc_out));
    exp_push("scan2_reg", 1);     chk(32'(reg_out));
    test_en = 1'b0; ce = 1'b0; fin = 4'hF; tick(); tick();
    exp_push("hold_out", 2'b10); chk(32'(fout));
    ce = 1'b1; tick();
    exp_push("ce_f_out", 2'b11); chk(32'(fout));
    fin = 4'hE; #1;
    exp_push("ff_latency", 2'b11); chk(32'(fout));
    tick();
    exp_push("ce_e_out", 2'b00); chk(32'(fout));

    // D-select: register chain into FF0, FF0 into FF1
    shift_word(W_DSEL);
    end_load();
    reg_in = 1'b1; tick();
    exp_push("dsel1_out", 2'b01); chk(32'(fout));
    reg_in = 1'b0; tick();
    exp_push("dsel2_out", 2'b10); chk(32'(fout));
    ce = 1'b0;

    // Reset in the middle of a load, cfg_en still high
    shift_ones(15);
    rst = 1'b1; cfg_en = 1'b1; tick();
    exp_push("midrst_done", 0); chk(32'(done));
    exp_push("midrst_tail", 0); chk(32'(tail));
    rst = 1'b0; cfg_en = 1'b0; tick();
    exp_push("midrst_state_done", 0); chk(32'(done));
    exp_push("midrst_state_err", 0);  chk(32'(err));
    exp_push("midrst_cfg_tail", 0);   chk(32'(tail));

    // Over-long load: counter saturates, last 22 bits define the config
    shift_ones(22);
    exp_push("ones_tail", 1); chk(32'(tail));
    shift_ones(8);
    shift_word(W_AND);
    end_load();
    exp_push("sat_done", 1); chk(32'(done));
    exp_push("sat_err", 0);  chk(32'(err));
    fin = 4'hF; #1;
    exp_push("sat_f", 2'b11); chk(32'(fout));
    fin = 4'hE; #1;
    exp_push("sat_e", 2'b00); chk(32'(fout));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
